fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_fifo.sv | 43 ++++
 rtl/fetch_unit.sv | 60 ++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: FSM encoding, instruction field positions and PC step
// shared by the fetch unit and its consumers.
package fetch_unit_pkg;
    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int FUNC_HI = 26;
    localparam int FUNC_LO = 23;
    localparam int RS1_HI  = 22;
    localparam int RS1_LO  = 19;
    localparam int RS2_HI  = 18;
    localparam int RS2_LO  = 15;
    localparam int RD_HI   = 14;
    localparam int RD_LO   = 11;
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus, redirect and decode-side handshake.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular FIFO with flush; push and pop may
// coincide even when full since the head is read from registered storage.
module fetch_fifo #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [W-1:0]         i_din,
    output logic [W-1:0]         o_dout,
    output logic [$clog2(D):0]   o_count
);
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    assign o_dout  = r_mem[r_rp];
    assign o_count = r_cnt;
    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_pop && r_cnt == '0));
    a_no_overflow:  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && !i_pop && r_cnt == CW'(D)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetcher with in-order response
// matching, an instruction buffer and redirect/drain handling.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic         i_clk,
    input logic         i_rst_n,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    state_t        r_state, w_state_nx;
    logic [31:0]   r_pc, w_pc_nx;
    logic [CW-1:0] r_out, w_out_nx;
    logic          r_go;
    logic          w_acc, w_resp, w_pop;
    logic [31:0]   w_pend_addr;
    logic [63:0]   w_head;
    logic [CW-1:0] w_cnt, w_pend_cnt;
    // Credit: buffered plus in-flight must leave room for every response.
    assign bus.imem_req  = r_go && r_state == FETCH && (SW'(w_cnt) + SW'(r_out) < SW'(DEPTH));
    assign bus.imem_addr = r_pc;
    assign w_acc         = bus.imem_req && bus.imem_ready;
    assign w_resp        = bus.imem_valid && r_state == FETCH;
    assign bus.instr_valid = w_cnt != '0;
    assign bus.instr       = w_head[63:32];
    assign bus.instr_pc    = w_head[31:0];
    assign w_pop           = bus.instr_valid && bus.instr_ready;
    fetch_fifo #(.W(32), .D(DEPTH)) u_pend (
        .i_clk, .i_rst_n, .i_flush(bus.redirect), .i_push(w_acc), .i_pop(w_resp),
        .i_din(r_pc), .o_dout(w_pend_addr), .o_count(w_pend_cnt)
    );
    fetch_fifo #(.W(64), .D(DEPTH)) u_buf (
        .i_clk, .i_rst_n, .i_flush(bus.redirect), .i_push(w_resp), .i_pop(w_pop),
        .i_din({bus.imem_rdata, w_pend_addr}), .o_dout(w_head), .o_count(w_cnt)
    );
    // A request accepted in the redirect cycle still counts, so it forces DRAIN.
    always_comb begin
        w_out_nx   = r_out + CW'(w_acc) - CW'(bus.imem_valid);
        w_pc_nx    = bus.redirect ? align_pc(bus.redirect_pc) : (w_acc ? r_pc + PC_INC : r_pc);
        w_state_nx = (r_state == FETCH) ? ((bus.redirect && w_out_nx != '0) ? DRAIN : FETCH)
                                        : ((w_out_nx == '0) ? FETCH : DRAIN);
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_go    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_out   <= w_out_nx;
            r_go    <= 1'b1;
        end
    a_resp_expected: assert property (@(posedge i_clk) disable iff (!i_rst_n) bus.imem_valid |-> r_out != '0);
    a_out_bound:     assert property (@(posedge i_clk) disable iff (!i_rst_n) SW'(r_out) <= SW'(DEPTH));
    a_pend_tracks:   assert property (@(posedge i_clk) disable iff (!i_rst_n) r_state == FETCH |-> w_pend_cnt == r_out);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-level model of the fetch stream (epochs, in-order memory,
// buffer occupancy) checked every cycle, plus directed literal scenarios.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    typedef struct { logic [31:0] addr; int ep; int due; } req_t;
    logic clk = 1'b0, rst_n, rst2_n;
    always #5 clk = ~clk;
    fetch_unit_if bus();
    fetch_unit_if bus2();
    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (.i_clk(clk), .i_rst_n(rst2_n), .bus(bus2));
    int n_chk = 0, n_err = 0;
    req_t mq[$];
    logic [31:0] bq[$], cons[$], q2[$];
    logic [31:0] fetch_pc, first_acc, g_rpc;
    int ep, cyc, rel, first_vrel, n_disc;
    int g_rp, g_ip, g_vp, g_lmin, g_lmax;
    logic g_rst_n, g_redir, g_block, have_acc, last_req, last_iv;
    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic mark();
        cons.delete();
        have_acc = 0;
        first_acc = 32'h0;
        n_disc = 0;
        first_vrel = -1;
    endtask
    task automatic step();
        logic rd, resp, acc, stale, exp_req;
        req_t r;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = g_rst_n;
        rel = rst_n ? rel + 1 : -1;
        rd = g_redir && g_rst_n;
        g_redir = 0;
        bus.redirect = rd;
        bus.redirect_pc = rd ? g_rpc : $urandom;
        bus.imem_ready = (rd && g_block) ? 1'b0 : ($urandom_range(99) < g_rp);
        bus.instr_ready = ($urandom_range(99) < g_ip);
        if (!rst_n) begin
            mq.delete();
            bq.delete();
            fetch_pc = 32'h0;
            ep = 0;
        end
        resp = rst_n && mq.size() > 0 && mq[0].due <= cyc && ($urandom_range(99) < g_vp);
        bus.imem_valid = resp;
        bus.imem_rdata = resp ? f(mq[0].addr) : $urandom;
        #4;
        if (!rst_n) begin
            chk("rst_imem_req", 32'(bus.imem_req), 0);
            chk("rst_instr_valid", 32'(bus.instr_valid), 0);
            chk("rst_imem_addr", bus.imem_addr, 32'h0);
            chk("rst_instr", bus.instr, 32'h0);
            chk("rst_instr_pc", bus.instr_pc, 32'h0);
        end else begin
            stale = 0;
            foreach (mq[i]) if (mq[i].ep != ep) stale = 1;
            exp_req = rel >= 1 && !stale && (bq.size() + mq.size() < DEPTH);
            chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", bus.imem_addr, fetch_pc);
            chk("instr_valid", 32'(bus.instr_valid), 32'(bq.size() != 0));
            if (bq.size() != 0) begin
                chk("instr_pc", bus.instr_pc, bq[0]);
                chk("instr", bus.instr, f(bq[0]));
            end
            last_req = bus.imem_req;
            last_iv = bus.instr_valid;
            if (bus.instr_valid && first_vrel < 0) first_vrel = rel;
            acc = bus.imem_req && bus.imem_ready;
            if (!rd && bq.size() > 0 && bus.instr_ready) begin
                cons.push_back(bus.instr_pc);
                void'(bq.pop_front());
            end
            if (resp) begin
                r = mq.pop_front();
                if (!rd && r.ep == ep) bq.push_back(r.addr);
                else n_disc++;
            end
            if (acc) begin
                mq.push_back('{addr: bus.imem_addr, ep: ep, due: cyc + $urandom_range(g_lmax, g_lmin)});
                if (!have_acc) begin
                    have_acc = 1;
                    first_acc = bus.imem_addr;
                end
                fetch_pc = fetch_pc + 32'd4;
            end
            if (rd) begin
                bq.delete();
                ep++;
                fetch_pc = {g_rpc[31:2], 2'b00};
            end
        end
    endtask
    task automatic wait_first();
        for (int i = 0; i < 80 && cons.size() == 0; i++) step();
    endtask
    initial begin
        rst_n = 0;
        bus.imem_ready = 0; bus.imem_valid = 0; bus.imem_rdata = 0;
        bus.redirect = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
        g_rst_n = 0; g_redir = 0; g_block = 0; g_rpc = 0;
        g_rp = 100; g_ip = 100; g_vp = 100; g_lmin = 1; g_lmax = 1;
        cyc = 0; rel = -1; ep = 0; fetch_pc = 0;
        mark();
        repeat (3) step();
        g_rst_n = 1;
        repeat (8) step();
        chk("t1_first_valid_cycle", 32'(first_vrel), 3);
        chk("t1_consumed", 32'(cons.size()), 5);
        chk("t1_pc0", cons.size() > 0 ? cons[0] : 32'hDEAD_DEAD, 32'h0);
        chk("t1_pc1", cons.size() > 1 ? cons[1] : 32'hDEAD_DEAD, 32'h4);
        chk("t1_pc2", cons.size() > 2 ? cons[2] : 32'hDEAD_DEAD, 32'h8);
        g_ip = 0;
        repeat (10) step();
        chk("t2_stall_req", 32'(last_req), 0);
        chk("t2_stall_valid", 32'(last_iv), 1);
        chk("t2_buffered", 32'(bq.size()), DEPTH);
        mark();
        g_ip = 100;
        repeat (6) step();
        chk("t2_resume_pc0", cons.size() > 0 ? cons[0] : 32'hDEAD_DEAD, 32'd20);
        chk("t2_resume_pc1", cons.size() > 1 ? cons[1] : 32'hDEAD_DEAD, 32'd24);
        chk("t2_resume_pc2", cons.size() > 2 ? cons[2] : 32'hDEAD_DEAD, 32'd28);
        chk("t2_resume_pc3", cons.size() > 3 ? cons[3] : 32'hDEAD_DEAD, 32'd32);
        g_lmin = 3; g_lmax = 3; g_block = 1;
        for (int i = 0; i < 40 && mq.size() != 3; i++) step();
        chk("t3_outstanding", 32'(mq.size()), 3);
        mark();
        g_redir = 1; g_rpc = 32'h100;
        step();
        step();
        chk("t3_drain_req", 32'(last_req), 0);
        chk("t3_flush_valid", 32'(last_iv), 0);
        wait_first();
        chk("t3_next_addr", first_acc, 32'h100);
        chk("t3_first_pc", cons.size() > 0 ? cons[0] : 32'hDEAD_DEAD, 32'h100);
        chk("t3_discarded", 32'(n_disc), 3);
        for (int i = 0; i < 40 && mq.size() < 2; i++) step();
        chk("t4_outstanding", 32'(mq.size() >= 2), 1);
        mark();
        g_redir = 1; g_rpc = 32'h40;
        step();
        g_redir = 1; g_rpc = 32'h80;
        step();
        wait_first();
        chk("t4_next_addr", first_acc, 32'h80);
        chk("t4_first_pc", cons.size() > 0 ? cons[0] : 32'hDEAD_DEAD, 32'h80);
        g_block = 0; g_lmin = 1; g_lmax = 4; g_rp = 70; g_ip = 60; g_vp = 75;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(99) < 2) begin
                    g_redir = 1;
                    g_rpc = $urandom;
                end
                step();
            end
            g_redir = 0;
            g_rst_n = 0;
            repeat (2) step();
            g_rst_n = 1;
        end
        chk("r2_pc0", q2.size() > 0 ? q2[0] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
        chk("r2_pc1", q2.size() > 1 ? q2[1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
        chk("r2_pc2", q2.size() > 2 ? q2[2] : 32'hDEAD_DEAD, 32'h0000_0000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
    initial begin
        logic nv;
        logic [31:0] na;
        rst2_n = 0; nv = 0; na = 0;
        bus2.imem_ready = 1; bus2.instr_ready = 1; bus2.redirect = 0;
        bus2.redirect_pc = 0; bus2.imem_valid = 0; bus2.imem_rdata = 0;
        @(negedge clk);
        chk("r2_reset_addr", bus2.imem_addr, 32'hFFFF_FFF8);
        chk("r2_reset_req", 32'(bus2.imem_req), 0);
        @(posedge clk);
        #1 rst2_n = 1;
        repeat (12) begin
            @(negedge clk);
            nv = bus2.imem_req && bus2.imem_ready;
            na = bus2.imem_addr;
            if (bus2.instr_valid) q2.push_back(bus2.instr_pc);
            @(posedge clk);
            #1;
            bus2.imem_valid = nv;
            bus2.imem_rdata = f(na);
        end
        bus2.imem_valid = 0;
    end
endmodule
